sram_controller: RTL
====================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter ADR, default 8, address width in bits.
REQ-002 Parameter DAT, default 8, data width in bits.
REQ-003 Parameter DPTH, default 8, number of implemented SRAM words.
REQ-004 Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 ResetN  input  1  asynchronous, active-low reset.
REQ-006 ReqValid  input  1  request present.
REQ-007 ReqReady  output  1  controller accepts a request this cycle.
REQ-008 ReqWrite  input  1  1 = write, 0 = read.
REQ-009 ReqAddr  input  ADR  request word address.
REQ-010 ReqData  input  DAT  write data.
REQ-011 RspValid  output  1  read response present.
REQ-012 RspReady  input  1  consumer takes the response.
REQ-013 RspData  output  DAT  read data.
REQ-014 RspErr  output  1  response or write was out of range (see Configuration).
REQ-015 MemAddr  output  ADR  to SRAM Addr.
REQ-016 MemDataIn  output  DAT  to SRAM dataIn.
REQ-017 MemDataOut  input  DAT  from SRAM dataOut (registered in SRAM).
REQ-018 MemChipSelect, MemWriteEnable, MemReadEnable  output  1 each  to SRAM ChipSelect/WriteEnable/ReadEnable.

Function
REQ-019 FSM states: IDLE, ACCESS, CAPTURE, RESP; all outputs driven from registers or decoded state only.
REQ-020 ReqReady SHALL be 1 only in IDLE; a request is accepted on an edge with ReqValid && ReqReady, latching ReqWrite/ReqAddr/ReqData; IDLE->ACCESS.
REQ-021 In ACCESS, exactly one cycle: MemChipSelect=1, MemWriteEnable=ReqWrite latch, MemReadEnable=!ReqWrite latch, MemAddr/MemDataIn = latched values; never WE and RE both 1.
REQ-022 Outside ACCESS, MemChipSelect, MemWriteEnable, MemReadEnable SHALL be 0; MemAddr/MemDataIn hold last latched values.
REQ-023 ACCESS -> IDLE for write (next request acceptable one cycle after ACCESS); ACCESS -> CAPTURE for read.
REQ-024 At the CAPTURE exit edge, RspData <= MemDataOut, RspValid <= 1; CAPTURE -> RESP.
REQ-025 Read latency: RspValid rises on the 2nd edge after the acceptance edge; write occupies 2 cycles.
REQ-026 RESP: RspData/RspValid/RspErr held stable until an edge with RspReady=1; then RspValid <= 0, RESP -> IDLE; no new request accepted while in RESP.
REQ-027 RspReady outside RESP SHALL be ignored; ReqValid outside IDLE SHALL be ignored.
REQ-028 Address wrap: none; ReqAddr passed unmodified unless Configuration says otherwise.

Reset
REQ-029 ResetN=0 SHALL immediately (asynchronously) force IDLE, ReqReady=1 after release, RspValid=0, RspData=0, RspErr=0, MemAddr=0, MemDataIn=0, all Mem strobes 0.
REQ-030 Reset during ACCESS, CAPTURE or RESP SHALL abort the transaction and discard any pending response.

Configuration
REQ-031 Macro SRAM_CTRL_BOUNDS_CHECK_EN: when defined, a request with ReqAddr >= DPTH still passes through ACCESS but with all Mem strobes 0; a read returns RspData=0 with RspErr=1; a write sets RspErr=1 for the ACCESS cycle only (not sticky); in-range requests give RspErr=0.
REQ-032 When undefined, RspErr SHALL be constant 0 and all addresses go to the SRAM unchecked.

Verification
REQ-033 Write 0xA5 to addr 3, then read addr 3 -> ACCESS shows CS=1/WE=1/RE=0/Addr=3/DataIn=0xA5; read gives RspValid 2 edges after accept, RspData=0xA5, RspErr=0.
REQ-034 Read addr 5 with RspReady=0 for 4 cycles -> RspValid/RspData held 4 cycles, ReqReady=0 throughout; RspReady=1 -> IDLE next edge.
REQ-035 Back-to-back writes addr 0..7 with ReqValid held high -> one accept every 2 cycles, strobes high exactly 1 cycle each, WE/RE never simultaneously 1.
REQ-036 Assert ResetN=0 in CAPTURE of a read -> strobes and RspValid 0 immediately; after release no response appears, ReqReady=1.
REQ-037 With SRAM_CTRL_BOUNDS_CHECK_EN, read addr 8 (DPTH=8) -> CS=0 in ACCESS, RspData=0x00, RspErr=1; without macro, same read -> CS=1, RspErr=0.
REQ-038 ReqValid pulsed during RESP and RspReady pulsed during IDLE -> neither request accepted nor state change.

Source files
------------

// File: rtl/sram_controller.sv
// Single-port SRAM request/response controller: one request in flight, fixed ACCESS/CAPTURE timing.
// Optional address bounds checking is enabled by defining SRAM_CTRL_BOUNDS_CHECK_EN.
module sram_controller #(
  parameter int ADR  = 8,
  parameter int DAT  = 8,
  parameter int DPTH = 8
) (
  input  logic           Clock,
  input  logic           ResetN,
  input  logic           ReqValid,
  output logic           ReqReady,
  input  logic           ReqWrite,
  input  logic [ADR-1:0] ReqAddr,
  input  logic [DAT-1:0] ReqData,
  output logic           RspValid,
  input  logic           RspReady,
  output logic [DAT-1:0] RspData,
  output logic           RspErr,
  output logic [ADR-1:0] MemAddr,
  output logic [DAT-1:0] MemDataIn,
  input  logic [DAT-1:0] MemDataOut,
  output logic           MemChipSelect,
  output logic           MemWriteEnable,
  output logic           MemReadEnable
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state;
  logic   req_write;
  logic   req_oor;
  logic   addr_oor;

  if (DPTH < 1) begin : g_bad_dpth
    $error("sram_controller: DPTH must be at least 1");
  end

`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
  // Widen before comparing so DPTH values above 2**ADR never truncate.
  assign addr_oor = ({{(64-ADR){1'b0}}, ReqAddr} >= 64'(DPTH));
`else
  assign addr_oor = 1'b0;
`endif

  assign ReqReady = (state == IDLE);

  // NOTE: every register here uses non-blocking assignment so all state updates
  // on an edge see the pre-edge values; blocking here would create order races.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state          <= IDLE;
      req_write      <= 1'b0;
      req_oor        <= 1'b0;
      MemAddr        <= '0;
      MemDataIn      <= '0;
      MemChipSelect  <= 1'b0;
      MemWriteEnable <= 1'b0;
      MemReadEnable  <= 1'b0;
      RspValid       <= 1'b0;
      RspData        <= '0;
      RspErr         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            req_write      <= ReqWrite;
            req_oor        <= addr_oor;
            MemAddr        <= ReqAddr;
            MemDataIn      <= ReqData;
            MemChipSelect  <= !addr_oor;
            MemWriteEnable <= ReqWrite && !addr_oor;
            MemReadEnable  <= !ReqWrite && !addr_oor;
            // An out-of-range write reports its error only while in ACCESS.
            RspErr         <= ReqWrite && addr_oor;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          MemChipSelect  <= 1'b0;
          MemWriteEnable <= 1'b0;
          MemReadEnable  <= 1'b0;
          RspErr         <= 1'b0;
          state          <= req_write ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          RspData  <= req_oor ? '0 : MemDataOut;
          RspErr   <= req_oor;
          RspValid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            RspErr   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_we_re_exclusive: assert property (@(posedge Clock) disable iff (!ResetN)
    !(MemWriteEnable && MemReadEnable));

  a_strobe_in_access: assert property (@(posedge Clock) disable iff (!ResetN)
    (MemChipSelect || MemWriteEnable || MemReadEnable) |-> (state == ACCESS));

endmodule
